// File: rtl/obb_sat_test_if.sv
// ============================================================================
// Module  : obb_sat_test_if
// Purpose : Request/result bundle between the collision controller and the
//           OBB separating-axis tester.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface obb_sat_test_if #(
  parameter int DW = 21
);
  logic                 start;
  logic signed [DW-1:0] m [9];
  logic signed [DW-1:0] t [3];
  logic signed [DW-1:0] a [3];
  logic signed [DW-1:0] b [3];
  logic                 busy;
  logic                 done;
  logic                 collide;
  logic [3:0]           sep_axis;

  modport master (output start, m, t, a, b, input busy, done, collide, sep_axis);
  modport slave  (input start, m, t, a, b, output busy, done, collide, sep_axis);
endinterface

`default_nettype wire

// File: rtl/obb_sat_test.sv
// ============================================================================
// Module  : obb_sat_test
// Purpose : 15-axis OBB separating-axis test, one axis per cycle.
//           Optional macro OBB_SAT_EARLY_EXIT_EN: stop at first separating axis.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module obb_sat_test #(
  parameter int DW   = 21,
  parameter int FRAC = 6,
  parameter int EPS  = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  obb_sat_test_if.slave   bus
);

  localparam int PW = 2*DW-1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_TEST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] NO_AXIS   = 4'd15;
  localparam logic [3:0] LAST_AXIS = 4'd14;

  typedef logic signed [DW-1:0] word_t;
  typedef logic signed [PW-1:0] acc_t;

  function automatic acc_t sext(input word_t x);
    return {{(PW-DW){x[DW-1]}}, x};
  endfunction

  function automatic acc_t fmul(input word_t x, input word_t y);
    acc_t p;
    p = sext(x) * sext(y);
    return p >>> FRAC;
  endfunction

  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [3:0] sep_q, sep_d;
  logic       collide_q, collide_d;
  word_t      r_q [9], r_d [9];
  word_t      absr_q [9], absr_d [9];
  word_t      t_q [3], t_d [3];
  word_t      a_q [3], a_d [3];
  word_t      b_q [3], b_d [3];

  logic [1:0] w_ci, w_cj, w_ci1, w_ci2, w_cj1, w_cj2;
  logic [3:0] w_kk;
  acc_t       w_d, w_ra, w_rb, w_abs_d;
  logic       w_sep, w_last;

  // Axis evaluation for the current k: projected distance and both radii
  always_comb begin
    w_ci = 2'd0;
    w_cj = 2'd0;
    w_kk = 4'd0;
    w_d  = '0;
    w_ra = '0;
    w_rb = '0;
    if (k_q < 4'd3) begin
      w_ci = k_q[1:0];
      w_d  = sext(t_q[w_ci]);
      w_ra = sext(a_q[w_ci]);
      w_rb = fmul(b_q[0], absr_q[idx(w_ci, 2'd0)])
           + fmul(b_q[1], absr_q[idx(w_ci, 2'd1)])
           + fmul(b_q[2], absr_q[idx(w_ci, 2'd2)]);
    end else if (k_q < 4'd6) begin
      w_kk = k_q - 4'd3;
      w_cj = w_kk[1:0];
      w_d  = fmul(t_q[0], r_q[idx(2'd0, w_cj)])
           + fmul(t_q[1], r_q[idx(2'd1, w_cj)])
           + fmul(t_q[2], r_q[idx(2'd2, w_cj)]);
      w_ra = fmul(a_q[0], absr_q[idx(2'd0, w_cj)])
           + fmul(a_q[1], absr_q[idx(2'd1, w_cj)])
           + fmul(a_q[2], absr_q[idx(2'd2, w_cj)]);
      w_rb = sext(b_q[w_cj]);
    end else begin
      w_kk = k_q - 4'd6;
      case (w_kk)
        4'd0, 4'd1, 4'd2: w_ci = 2'd0;
        4'd3, 4'd4, 4'd5: w_ci = 2'd1;
        default:          w_ci = 2'd2;
      endcase
      case (w_kk)
        4'd0, 4'd3, 4'd6: w_cj = 2'd0;
        4'd1, 4'd4, 4'd7: w_cj = 2'd1;
        default:          w_cj = 2'd2;
      endcase
    end
    w_ci1 = nxt(w_ci);
    w_ci2 = nxt(w_ci1);
    w_cj1 = nxt(w_cj);
    w_cj2 = nxt(w_cj1);
    if (k_q >= 4'd6) begin
      w_d  = fmul(t_q[w_ci2], r_q[idx(w_ci1, w_cj)])
           - fmul(t_q[w_ci1], r_q[idx(w_ci2, w_cj)]);
      w_ra = fmul(a_q[w_ci1], absr_q[idx(w_ci2, w_cj)])
           + fmul(a_q[w_ci2], absr_q[idx(w_ci1, w_cj)]);
      w_rb = fmul(b_q[w_cj1], absr_q[idx(w_ci, w_cj2)])
           + fmul(b_q[w_cj2], absr_q[idx(w_ci, w_cj1)]);
    end
    w_abs_d = w_d[PW-1] ? -w_d : w_d;
    w_sep   = w_abs_d > (w_ra + w_rb);
  end

`ifdef OBB_SAT_EARLY_EXIT_EN
  assign w_last = (k_q == LAST_AXIS) || w_sep;
`else
  assign w_last = (k_q == LAST_AXIS);
`endif

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sep_d     = sep_q;
    collide_d = collide_q;
    r_d       = r_q;
    absr_d    = absr_q;
    t_d       = t_q;
    a_d       = a_q;
    b_d       = b_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = bus.m;
          t_d     = bus.t;
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int i = 0; i < 9; i++) begin
          absr_d[i] = (r_q[i][DW-1] ? -r_q[i] : r_q[i]) + word_t'(EPS);
        end
        sep_d     = NO_AXIS;
        collide_d = 1'b0;
        k_d       = 4'd0;
        state_d   = S_TEST;
      end
      S_TEST: begin
        // Only the first separating axis is recorded
        if (w_sep && (sep_q == NO_AXIS)) begin
          sep_d = k_q;
        end
        k_d = k_q + 4'd1;
        if (w_last) begin
          k_d       = 4'd0;
          collide_d = (sep_d == NO_AXIS);
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= 4'd0;
      sep_q     <= NO_AXIS;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sep_q     <= sep_d;
      collide_q <= collide_d;
    end
  end

  always_ff @(posedge clk) begin
    r_q    <= r_d;
    absr_q <= absr_d;
    t_q    <= t_d;
    a_q    <= a_d;
    b_q    <= b_d;
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.collide  = collide_q;
  assign bus.sep_axis = sep_q;

endmodule

`default_nettype wire

// File: tb/tb_obb_sat_test.sv
// ============================================================================
// Module  : tb_obb_sat_test
// Purpose : Scoreboard bench for obb_sat_test (directed + random boxes).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_obb_sat_test;

  localparam int DW = 21;

  typedef struct {
    logic       col;
    logic [3:0] sep;
    int         cyc0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_done;
  exp_t sb[$];

  obb_sat_test_if #(.DW(DW)) bus ();

  obb_sat_test #(.DW(DW), .FRAC(6), .EPS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input int sep);
`ifdef OBB_SAT_EARLY_EXIT_EN
    return (sep == 15) ? 16 : 2 + sep;
`else
    return 16;
`endif
  endfunction

  function automatic longint fm(input longint x, input longint y);
    return (x * y) >>> 6;
  endfunction

  // Reference separating-axis test written directly from the box formulas
  function automatic int model_sep(input int mv[9], input int tv[3],
                                   input int av[3], input int bv[3]);
    longint ar[9];
    longint d, ra, rb;
    int i, j, i1, i2, j1, j2;
    for (int n = 0; n < 9; n++) ar[n] = longint'((mv[n] < 0) ? -mv[n] : mv[n]) + 1;
    for (int k = 0; k < 15; k++) begin
      if (k < 3) begin
        i  = k;
        d  = tv[i];
        ra = av[i];
        rb = fm(bv[0], ar[3*i]) + fm(bv[1], ar[3*i+1]) + fm(bv[2], ar[3*i+2]);
      end else if (k < 6) begin
        j  = k - 3;
        d  = fm(tv[0], mv[j]) + fm(tv[1], mv[3+j]) + fm(tv[2], mv[6+j]);
        ra = fm(av[0], ar[j]) + fm(av[1], ar[3+j]) + fm(av[2], ar[6+j]);
        rb = bv[j];
      end else begin
        i  = (k - 6) / 3;
        j  = (k - 6) % 3;
        i1 = (i + 1) % 3;  i2 = (i + 2) % 3;
        j1 = (j + 1) % 3;  j2 = (j + 2) % 3;
        d  = fm(tv[i2], mv[3*i1+j]) - fm(tv[i1], mv[3*i2+j]);
        ra = fm(av[i1], ar[3*i2+j]) + fm(av[i2], ar[3*i1+j]);
        rb = fm(bv[j1], ar[3*i+j2]) + fm(bv[j2], ar[3*i+j1]);
      end
      if (((d < 0) ? -d : d) > ra + rb) return k;
    end
    return 15;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("collide", int'(bus.collide), int'(e.col));
        chk("sep_axis", int'(bus.sep_axis), int'(e.sep));
        chk("latency", cyc - e.cyc0, exp_lat(int'(e.sep)));
        chk("busy_in_done", int'(bus.busy), 1);
      end
    end
  end

  task automatic launch(input int mv[9], input int tv[3], input int av[3],
                        input int bv[3], input int exp_sep);
    exp_t e;
    @(negedge clk);
    for (int n = 0; n < 9; n++) bus.m[n] = DW'(mv[n]);
    for (int n = 0; n < 3; n++) begin
      bus.t[n] = DW'(tv[n]);
      bus.a[n] = DW'(av[n]);
      bus.b[n] = DW'(bv[n]);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.col  = (exp_sep == 15);
    e.sep  = exp_sep[3:0];
    e.cyc0 = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic run_case(input int mv[9], input int tv[3], input int av[3],
                          input int bv[3], input int exp_sep);
    launch(mv, tv, av, bv, exp_sep);
    chk("busy_after_start", int'(bus.busy), 1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sep", int'(bus.sep_axis), exp_sep);
    chk("hold_busy", int'(bus.busy), 0);
  endtask

  initial begin
    int ident[9], rotz[9], zero3[3], e64[3], e32[3];
    int mv[9], tv[3], av[3], bv[3];
    int snap;
    n_cmp = 0; n_err = 0; n_done = 0; cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    for (int n = 0; n < 9; n++) bus.m[n] = '0;
    for (int n = 0; n < 3; n++) begin
      bus.t[n] = '0; bus.a[n] = '0; bus.b[n] = '0;
    end
    ident = '{64, 0, 0, 0, 64, 0, 0, 0, 64};
    rotz  = '{0, -64, 0, 64, 0, 0, 0, 0, 64};
    zero3 = '{0, 0, 0};
    e64   = '{64, 64, 64};
    e32   = '{32, 32, 32};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_collide", int'(bus.collide), 0);
    chk("rst_sep", int'(bus.sep_axis), 15);
    rst_n = 1'b1;

    run_case(ident, zero3, e64, e64, 15);
    tv = '{132, 0, 0};
    run_case(ident, tv, e64, e64, 0);
    tv = '{131, 0, 0};
    run_case(ident, tv, e64, e64, 15);
    tv = '{-132, 0, 0};
    run_case(ident, tv, e64, e64, 0);
    tv = '{0, 100, 0};
    av = '{128, 32, 32};
    run_case(rotz, tv, av, e32, 1);

    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 9; n++) mv[n] = int'($urandom_range(128)) - 64;
      for (int n = 0; n < 3; n++) begin
        tv[n] = int'($urandom_range(400)) - 200;
        av[n] = int'($urandom_range(100));
        bv[n] = int'($urandom_range(100));
      end
      run_case(mv, tv, av, bv, model_sep(mv, tv, av, bv));
    end

    // Second start during TEST must be ignored
    snap = n_done;
    launch(ident, zero3, e64, e64, 15);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);
    chk("single_done", n_done - snap, 1);

    // Reset in the middle of TEST aborts with no done
    snap = n_done;
    launch(ident, zero3, e64, e64, 15);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_sep", int'(bus.sep_axis), 15);
    chk("midrst_collide", int'(bus.collide), 0);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("no_done_after_rst", n_done - snap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
